// File: rtl/pll_seq_pkg.sv
// Shared types and default timing constants for the PLL lock sequencer.
// The state encoding and default cycle counts live here so that the
// sequencer and its testbench agree on them.
package pll_seq_pkg;

    typedef enum logic [2:0] {
        RESET_HOLD,
        WAIT_LOCK,
        STABILIZE,
        RUN,
        FAIL
    } pll_state_e;

    // Defaults sized for a 50 MHz reference clock.
    localparam int unsigned DEF_RST_HOLD_CYCLES     = 100;    // 2 us PLL reset pulse
    localparam int unsigned DEF_LOCK_TIMEOUT_CYCLES = 50000;  // 1 ms lock window
    localparam int unsigned DEF_LOCK_STABLE_CYCLES  = 1024;   // lock must hold this long
    localparam int unsigned DEF_MAX_RETRIES         = 3;      // attempts after the first
    localparam int unsigned DEF_CNT_W               = 16;     // shared cycle counter width

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchroniser for asynchronous status inputs.
// q follows d two clk edges later; both flops clear on async reset.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [1:0] sync_reg;

    // Shift the asynchronous input through two flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_reg <= 2'b00;
        end else begin
            sync_reg <= {sync_reg[0], d};
        end
    end

    assign q = sync_reg[1];

endmodule

// File: rtl/pll_lock_sequencer.sv
// PLL reset / lock sequencer on the 50 MHz reference clock.
// Pulses the PLL reset, waits for lock, requires lock to stay stable before
// releasing the downstream reset, retries on timeout and re-sequences on
// lock loss. Optional build macro PLL_LOSS_CNT_EN adds loss_cnt_o, a
// saturating count of lock losses while running.
module pll_lock_sequencer
    import pll_seq_pkg::*;
#(
    parameter int unsigned RST_HOLD_CYCLES     = DEF_RST_HOLD_CYCLES,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
    parameter int unsigned LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
    parameter int unsigned MAX_RETRIES         = DEF_MAX_RETRIES,
    parameter int unsigned CNT_W               = DEF_CNT_W
) (
    input  logic       refclk,
    input  logic       rst_n,
    input  logic       pll_locked_i,
    input  logic       relock_req_i,
    output logic       pll_rst_o,
    output logic       sys_rst_n_o,
    output logic       ready_o,
    output logic       fail_o,
`ifdef PLL_LOSS_CNT_EN
    output logic [7:0] loss_cnt_o,
`endif
    output logic [1:0] retry_cnt_o
);

    // Terminal counts: each state counts from 0, so the last cycle is N-1.
    localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(RST_HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [1:0]       RETRY_MAX    = 2'(MAX_RETRIES);

    pll_state_e       state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [1:0]       retry_cnt_reg;
    logic             pll_rst_reg;
    logic             sys_rst_n_reg;
    logic             ready_reg;
    logic             fail_reg;
    logic             lock_s;

    sync_2ff u_lock_sync (
        .clk   (refclk),
        .rst_n (rst_n),
        .d     (pll_locked_i),
        .q     (lock_s)
    );

    // Sequencer FSM; outputs are set on the same edge that enters a state,
    // so they always agree with the registered state.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= RESET_HOLD;
            cnt_reg       <= '0;
            retry_cnt_reg <= 2'd0;
            pll_rst_reg   <= 1'b1;
            sys_rst_n_reg <= 1'b0;
            ready_reg     <= 1'b0;
            fail_reg      <= 1'b0;
        end else if (relock_req_i) begin
            // A forced re-sequence overrides whatever the current state wants.
            state_reg     <= RESET_HOLD;
            cnt_reg       <= '0;
            retry_cnt_reg <= 2'd0;
            pll_rst_reg   <= 1'b1;
            sys_rst_n_reg <= 1'b0;
            ready_reg     <= 1'b0;
            fail_reg      <= 1'b0;
        end else begin
            case (state_reg)
                RESET_HOLD: begin
                    if (cnt_reg == HOLD_LAST) begin
                        state_reg   <= WAIT_LOCK;
                        cnt_reg     <= '0;
                        pll_rst_reg <= 1'b0;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                WAIT_LOCK: begin
                    // Lock is tested first so it wins on the timeout cycle.
                    if (lock_s) begin
                        state_reg <= STABILIZE;
                        cnt_reg   <= '0;
                    end else if (cnt_reg == TIMEOUT_LAST) begin
                        cnt_reg     <= '0;
                        pll_rst_reg <= 1'b1;
                        if (retry_cnt_reg < RETRY_MAX) begin
                            state_reg     <= RESET_HOLD;
                            retry_cnt_reg <= retry_cnt_reg + 1'b1;
                        end else begin
                            state_reg <= FAIL;
                            fail_reg  <= 1'b1;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                STABILIZE: begin
                    // A lock glitch restarts the lock window without using a retry.
                    if (!lock_s) begin
                        state_reg <= WAIT_LOCK;
                        cnt_reg   <= '0;
                    end else if (cnt_reg == STABLE_LAST) begin
                        state_reg     <= RUN;
                        cnt_reg       <= '0;
                        sys_rst_n_reg <= 1'b1;
                        ready_reg     <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                RUN: begin
                    if (!lock_s) begin
                        state_reg     <= RESET_HOLD;
                        cnt_reg       <= '0;
                        retry_cnt_reg <= 2'd0;
                        pll_rst_reg   <= 1'b1;
                        sys_rst_n_reg <= 1'b0;
                        ready_reg     <= 1'b0;
                    end
                end
                FAIL: begin
                    // Terminal: only relock_req_i or rst_n leaves this state.
                    cnt_reg <= '0;
                end
                default: begin
                    state_reg     <= RESET_HOLD;
                    cnt_reg       <= '0;
                    retry_cnt_reg <= 2'd0;
                    pll_rst_reg   <= 1'b1;
                    sys_rst_n_reg <= 1'b0;
                    ready_reg     <= 1'b0;
                    fail_reg      <= 1'b0;
                end
            endcase
        end
    end

`ifdef PLL_LOSS_CNT_EN
    logic [7:0] loss_cnt_reg;
    logic       lock_loss;

    // Only a genuine lock loss while running counts, not a forced relock.
    assign lock_loss = !relock_req_i && (state_reg == RUN) && !lock_s;

    // Saturating lock-loss counter; survives relock requests.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            loss_cnt_reg <= 8'd0;
        end else if (lock_loss && (loss_cnt_reg != 8'hFF)) begin
            loss_cnt_reg <= loss_cnt_reg + 8'd1;
        end
    end

    assign loss_cnt_o = loss_cnt_reg;
`endif

    assign pll_rst_o   = pll_rst_reg;
    assign sys_rst_n_o = sys_rst_n_reg;
    assign ready_o     = ready_reg;
    assign fail_o      = fail_reg;
    assign retry_cnt_o = retry_cnt_reg;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed testbench for pll_lock_sequencer with shortened timing
// (hold 4, timeout 20, stable 8, 2 retries). Inputs change 1 time unit
// after a rising edge; outputs are sampled at the same point.
module tb_pll_lock_sequencer;

    localparam int unsigned RST_HOLD = 4;
    localparam int unsigned TIMEOUT  = 20;
    localparam int unsigned STABLE   = 8;
    localparam int unsigned RETRIES  = 2;

    logic       refclk = 1'b0;
    logic       rst_n;
    logic       pll_locked_i;
    logic       relock_req_i;
    logic       pll_rst_o;
    logic       sys_rst_n_o;
    logic       ready_o;
    logic       fail_o;
    logic [1:0] retry_cnt_o;
`ifdef PLL_LOSS_CNT_EN
    logic [7:0] loss_cnt_o;
`endif

    int tests_run    = 0;
    int tests_failed = 0;

    always #10 refclk = ~refclk;

    pll_lock_sequencer #(
        .RST_HOLD_CYCLES     (RST_HOLD),
        .LOCK_TIMEOUT_CYCLES (TIMEOUT),
        .LOCK_STABLE_CYCLES  (STABLE),
        .MAX_RETRIES         (RETRIES),
        .CNT_W               (16)
    ) dut (
        .refclk       (refclk),
        .rst_n        (rst_n),
        .pll_locked_i (pll_locked_i),
        .relock_req_i (relock_req_i),
        .pll_rst_o    (pll_rst_o),
        .sys_rst_n_o  (sys_rst_n_o),
        .ready_o      (ready_o),
        .fail_o       (fail_o),
`ifdef PLL_LOSS_CNT_EN
        .loss_cnt_o   (loss_cnt_o),
`endif
        .retry_cnt_o  (retry_cnt_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
        end else begin
            $display("[TB] ok   %s = %0d", tag, got);
        end
    endtask

    // Advance n rising edges and settle just after the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge refclk);
        #1;
    endtask

    initial begin
        rst_n        = 1'b0;
        pll_locked_i = 1'b0;
        relock_req_i = 1'b0;
        tick(3);

        // Reset values
        check("rst.pll_rst",   32'(pll_rst_o),   32'd1);
        check("rst.sys_rst_n", 32'(sys_rst_n_o), 32'd0);
        check("rst.ready",     32'(ready_o),     32'd0);
        check("rst.fail",      32'(fail_o),      32'd0);
        check("rst.retry",     32'(retry_cnt_o), 32'd0);
`ifdef PLL_LOSS_CNT_EN
        check("rst.loss",      32'(loss_cnt_o),  32'd0);
`endif

        // Nominal: 4-cycle hold, lock 10 cycles after pll_rst falls
        rst_n = 1'b1;
        tick(3);
        check("nom.hold_last", 32'(pll_rst_o), 32'd1);
        tick(1);
        check("nom.hold_done", 32'(pll_rst_o), 32'd0);
        tick(9);
        pll_locked_i = 1'b1;
        tick(10);
        check("nom.ready_early", 32'(ready_o), 32'd0);
        tick(1);
        check("nom.ready",     32'(ready_o),     32'd1);
        check("nom.sys_rst_n", 32'(sys_rst_n_o), 32'd1);
        check("nom.retry",     32'(retry_cnt_o), 32'd0);
        check("nom.pll_rst",   32'(pll_rst_o),   32'd0);

        // Lock loss in RUN: outputs drop 3 edges after the input falls
        pll_locked_i = 1'b0;
        tick(2);
        check("loss.ready_hold", 32'(ready_o), 32'd1);
        tick(1);
        check("loss.ready",     32'(ready_o),     32'd0);
        check("loss.sys_rst_n", 32'(sys_rst_n_o), 32'd0);
        check("loss.pll_rst",   32'(pll_rst_o),   32'd1);
        check("loss.retry",     32'(retry_cnt_o), 32'd0);
`ifdef PLL_LOSS_CNT_EN
        check("loss.loss_cnt",  32'(loss_cnt_o),  32'd1);
`endif
        tick(3);
        check("loss.hold_last", 32'(pll_rst_o), 32'd1);
        tick(1);
        check("loss.hold_done", 32'(pll_rst_o), 32'd0);

        // First attempt times out with lock low -> retry 1
        tick(19);
        check("to1.before_retry", 32'(retry_cnt_o), 32'd0);
        tick(1);
        check("to1.retry",   32'(retry_cnt_o), 32'd1);
        check("to1.pll_rst", 32'(pll_rst_o),   32'd1);
        tick(3);
        check("to1.hold_last", 32'(pll_rst_o), 32'd1);
        tick(1);
        check("to1.hold_done", 32'(pll_rst_o), 32'd0);

        // Glitch in STABILIZE during attempt 2: 5 high, 1 low, then high
        pll_locked_i = 1'b1;
        tick(5);
        pll_locked_i = 1'b0;
        tick(1);
        pll_locked_i = 1'b1;
        tick(2);
        check("gl.retry_kept", 32'(retry_cnt_o), 32'd1);
        tick(8);
        check("gl.ready_early", 32'(ready_o), 32'd0);
        tick(1);
        check("gl.ready", 32'(ready_o),     32'd1);
        check("gl.retry", 32'(retry_cnt_o), 32'd1);

        // Second lock loss clears the retry count
        pll_locked_i = 1'b0;
        tick(3);
        check("loss2.ready", 32'(ready_o),     32'd0);
        check("loss2.retry", 32'(retry_cnt_o), 32'd0);
`ifdef PLL_LOSS_CNT_EN
        check("loss2.loss_cnt", 32'(loss_cnt_o), 32'd2);
`endif

        // rst_n pulsed mid-STABILIZE
        pll_locked_i = 1'b1;
        tick(7);
        check("ars.pre_pll_rst", 32'(pll_rst_o), 32'd0);
        rst_n        = 1'b0;
        pll_locked_i = 1'b0;
        #1;
        check("ars.pll_rst",   32'(pll_rst_o),   32'd1);
        check("ars.sys_rst_n", 32'(sys_rst_n_o), 32'd0);
        check("ars.ready",     32'(ready_o),     32'd0);
        check("ars.retry",     32'(retry_cnt_o), 32'd0);
`ifdef PLL_LOSS_CNT_EN
        check("ars.loss_cnt",  32'(loss_cnt_o),  32'd0);
`endif
        tick(2);
        rst_n = 1'b1;

        // Timeout/retry to FAIL with lock held low
        tick(3);
        check("tr.hold_last", 32'(pll_rst_o), 32'd1);
        tick(1);
        check("tr.hold_done", 32'(pll_rst_o), 32'd0);
        tick(20);
        check("tr.retry1",    32'(retry_cnt_o), 32'd1);
        check("tr.pulse2",    32'(pll_rst_o),   32'd1);
        tick(3);
        check("tr.pulse2_last", 32'(pll_rst_o), 32'd1);
        tick(1);
        check("tr.pulse2_done", 32'(pll_rst_o), 32'd0);
        tick(20);
        check("tr.retry2",    32'(retry_cnt_o), 32'd2);
        check("tr.pulse3",    32'(pll_rst_o),   32'd1);
        tick(23);
        check("tr.fail_early", 32'(fail_o),    32'd0);
        check("tr.wait3",      32'(pll_rst_o), 32'd0);
        tick(1);
        check("tr.fail",      32'(fail_o),      32'd1);
        check("tr.fail_prst", 32'(pll_rst_o),   32'd1);
        check("tr.fail_retry", 32'(retry_cnt_o), 32'd2);
        check("tr.fail_sysrst", 32'(sys_rst_n_o), 32'd0);
        tick(30);
        check("tr.fail_held", 32'(fail_o),    32'd1);
        check("tr.prst_held", 32'(pll_rst_o), 32'd1);

        // relock_req_i in FAIL
        relock_req_i = 1'b1;
        tick(1);
        relock_req_i = 1'b0;
        check("rl.fail",    32'(fail_o),      32'd0);
        check("rl.pll_rst", 32'(pll_rst_o),   32'd1);
        check("rl.retry",   32'(retry_cnt_o), 32'd0);
        tick(3);
        check("rl.hold_last", 32'(pll_rst_o), 32'd1);
        tick(1);
        check("rl.hold_done", 32'(pll_rst_o), 32'd0);

        // relock_req_i on the WAIT_LOCK timeout cycle: relock wins
        tick(19);
        relock_req_i = 1'b1;
        tick(1);
        relock_req_i = 1'b0;
        check("rlto.retry",   32'(retry_cnt_o), 32'd0);
        check("rlto.fail",    32'(fail_o),      32'd0);
        check("rlto.pll_rst", 32'(pll_rst_o),   32'd1);
        tick(3);
        check("rlto.hold_last", 32'(pll_rst_o), 32'd1);
        tick(1);
        check("rlto.hold_done", 32'(pll_rst_o), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
